spi_flash_responder: RTL and testbench

SPI_FLASH_RESPONDER -- requirements
Module: spi_flash_responder

---
 rtl/spi_flash_responder_if.sv | 11 +
 rtl/spi_flash_responder.sv | 260 ++++++++++++++++++++++++++
 tb/tb_spi_flash_responder.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_flash_responder_if.sv
// Serial flash bus between an initiator and the spi_flash_responder.
// The master drives chip select and dq0; the slave returns data on dq[3:0].
interface spi_flash_responder_if;
   logic       flash_cs;
   logic       si;
   logic [3:0] dq_out;
   logic [3:0] dq_oe;

   modport master (output flash_cs, output si, input dq_out, input dq_oe);
   modport slave  (input flash_cs, input si, output dq_out, output dq_oe);
endinterface

// File: rtl/spi_flash_responder.sv
// Behavioural SPI NOR flash responder: WREN/WRDI/RDSR/READ/PROGRAM on a small byte array.
// Define SPI_FLASH_QUAD_READ_EN to add the 0x6B quad-output fast read.
module spi_flash_responder #(
   parameter int MEM_AW      = 8,
   parameter int BUSY_CYCLES = 64
) (
   input logic                  clk,
   input logic                  reset,
   spi_flash_responder_if.slave bus
);

   localparam int DEPTH  = 1 << MEM_AW;
   localparam int BUSY_W = $clog2(BUSY_CYCLES + 1);
   localparam logic [MEM_AW-1:0] PAGE_MASK = (MEM_AW > 8) ? MEM_AW'(255) : {MEM_AW{1'b1}};

   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_OPCODE   = 3'd1;
   localparam logic [2:0] S_ADDR     = 3'd2;
   localparam logic [2:0] S_DUMMY    = 3'd3;
   localparam logic [2:0] S_DATA_IN  = 3'd4;
   localparam logic [2:0] S_DATA_OUT = 3'd5;
   localparam logic [2:0] S_IGNORE   = 3'd6;

   localparam logic [1:0] CMD_READ  = 2'd0;
   localparam logic [1:0] CMD_PROG  = 2'd1;
   localparam logic [1:0] CMD_QREAD = 2'd2;
   localparam logic [1:0] CMD_RDSR  = 2'd3;

   logic [2:0]        state_q, state_d;
   logic [1:0]        cmd_q, cmd_d;
   logic [4:0]        cnt_q, cnt_d;
   logic [6:0]        sh_q, sh_d;
   logic [MEM_AW-1:0] addr_q, addr_d;
   logic [7:0]        out_byte_q, out_byte_d;
   logic [2:0]        pos_q, pos_d;
   logic              wel_q, wel_d;
   logic [BUSY_W-1:0] busy_q, busy_d;
   logic              prog_byte_q, prog_byte_d;
   logic [3:0]        dq_out_q, dq_out_d;
   logic [3:0]        dq_oe_q, dq_oe_d;
   logic [7:0]        mem_q [DEPTH];

   logic              mem_we;
   logic [MEM_AW-1:0] mem_waddr;
   logic [7:0]        mem_wdata;
   logic              start_en;
   logic [7:0]        start_byte;
   logic              quad_start;

   logic              wip;
   logic [7:0]        sample;
   logic [MEM_AW-1:0] addr_shift;
   logic [MEM_AW-1:0] addr_inc;
   logic [MEM_AW-1:0] prog_next;
   logic [7:0]        status;

   assign wip        = (busy_q != '0);
   assign sample     = {sh_q, bus.si};
   assign addr_shift = {addr_q[MEM_AW-2:0], bus.si};
   assign addr_inc   = addr_q + MEM_AW'(1);
   assign prog_next  = (addr_q & ~PAGE_MASK) | (addr_inc & PAGE_MASK);
   assign status     = {6'b0, wel_q, wip};

   assign bus.dq_out = dq_out_q;
   assign bus.dq_oe  = dq_oe_q;

   always_comb begin
      state_d     = state_q;
      cmd_d       = cmd_q;
      cnt_d       = cnt_q;
      sh_d        = sh_q;
      addr_d      = addr_q;
      out_byte_d  = out_byte_q;
      pos_d       = pos_q;
      wel_d       = wel_q;
      busy_d      = wip ? busy_q - BUSY_W'(1) : busy_q;
      prog_byte_d = prog_byte_q;
      dq_out_d    = dq_out_q;
      dq_oe_d     = dq_oe_q;
      mem_we      = 1'b0;
      mem_waddr   = addr_q;
      mem_wdata   = 8'h00;
      start_en    = 1'b0;
      start_byte  = 8'h00;
      quad_start  = 1'b0;

      if (bus.flash_cs) begin
         // Deselect ends any command; a program with a complete byte becomes busy here.
         state_d     = S_IDLE;
         cnt_d       = 5'd0;
         dq_out_d    = 4'b0000;
         dq_oe_d     = 4'b0000;
         prog_byte_d = 1'b0;
         if (state_q == S_DATA_IN && prog_byte_q) begin
            wel_d  = 1'b0;
            busy_d = BUSY_W'(BUSY_CYCLES);
         end
      end else begin
         case (state_q)
            S_IDLE: begin
               sh_d    = sample[6:0];
               cnt_d   = 5'd1;
               state_d = S_OPCODE;
            end
            S_OPCODE: begin
               sh_d  = sample[6:0];
               cnt_d = cnt_q + 5'd1;
               if (cnt_q == 5'd7) begin
                  cnt_d   = 5'd0;
                  state_d = S_IGNORE;
                  // While busy only the status read is honoured.
                  if (!wip || sample == 8'h05) begin
                     case (sample)
                        8'h06: wel_d = 1'b1;
                        8'h04: wel_d = 1'b0;
                        8'h05: begin
                           cmd_d      = CMD_RDSR;
                           state_d    = S_DATA_OUT;
                           start_en   = 1'b1;
                           start_byte = status;
                        end
                        8'h03: begin
                           cmd_d   = CMD_READ;
                           state_d = S_ADDR;
                        end
                        8'h02: begin
                           if (wel_q) begin
                              cmd_d   = CMD_PROG;
                              state_d = S_ADDR;
                           end
                        end
`ifdef SPI_FLASH_QUAD_READ_EN
                        8'h6B: begin
                           cmd_d   = CMD_QREAD;
                           state_d = S_ADDR;
                        end
`endif
                        default: ;
                     endcase
                  end
               end
            end
            S_ADDR: begin
               addr_d = addr_shift;
               cnt_d  = cnt_q + 5'd1;
               if (cnt_q == 5'd23) begin
                  cnt_d = 5'd0;
                  case (cmd_q)
                     CMD_READ: begin
                        state_d    = S_DATA_OUT;
                        start_en   = 1'b1;
                        start_byte = mem_q[addr_shift];
                     end
                     CMD_PROG:  state_d = S_DATA_IN;
                     CMD_QREAD: state_d = S_DUMMY;
                     default:   state_d = S_IGNORE;
                  endcase
               end
            end
            S_DUMMY: begin
               cnt_d = cnt_q + 5'd1;
               if (cnt_q == 5'd7) begin
                  cnt_d      = 5'd0;
                  state_d    = S_DATA_OUT;
                  start_en   = 1'b1;
                  start_byte = mem_q[addr_q];
               end
            end
            S_DATA_IN: begin
               sh_d  = sample[6:0];
               cnt_d = cnt_q + 5'd1;
               if (cnt_q == 5'd7) begin
                  cnt_d       = 5'd0;
                  mem_we      = 1'b1;
                  mem_waddr   = addr_q;
                  mem_wdata   = mem_q[addr_q] & sample;
                  addr_d      = prog_next;
                  prog_byte_d = 1'b1;
               end
            end
            S_DATA_OUT: begin
               if (pos_q == 3'd0) begin
                  start_en = 1'b1;
                  if (cmd_q == CMD_RDSR) begin
                     start_byte = status;
                  end else begin
                     addr_d     = addr_inc;
                     start_byte = mem_q[addr_inc];
                  end
               end else begin
                  pos_d = pos_q - 3'd1;
                  if (cmd_q == CMD_QREAD) dq_out_d = out_byte_q[3:0];
                  else                    dq_out_d = {2'b00, out_byte_q[pos_q - 3'd1], 1'b0};
               end
            end
            S_IGNORE: ;
            default: state_d = S_IDLE;
         endcase

`ifdef SPI_FLASH_QUAD_READ_EN
         quad_start = (cmd_d == CMD_QREAD);
`else
         quad_start = 1'b0;
`endif
         // First beat of a new output byte: MSB on dq1, or high nibble on all four lines.
         if (start_en) begin
            out_byte_d = start_byte;
            if (quad_start) begin
               dq_out_d = start_byte[7:4];
               dq_oe_d  = 4'b1111;
               pos_d    = 3'd1;
            end else begin
               dq_out_d = {2'b00, start_byte[7], 1'b0};
               dq_oe_d  = 4'b0010;
               pos_d    = 3'd7;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         cmd_q       <= CMD_READ;
         cnt_q       <= 5'd0;
         sh_q        <= 7'd0;
         addr_q      <= '0;
         out_byte_q  <= 8'h00;
         pos_q       <= 3'd0;
         wel_q       <= 1'b0;
         busy_q      <= '0;
         prog_byte_q <= 1'b0;
         dq_out_q    <= 4'b0000;
         dq_oe_q     <= 4'b0000;
      end else begin
         state_q     <= state_d;
         cmd_q       <= cmd_d;
         cnt_q       <= cnt_d;
         sh_q        <= sh_d;
         addr_q      <= addr_d;
         out_byte_q  <= out_byte_d;
         pos_q       <= pos_d;
         wel_q       <= wel_d;
         busy_q      <= busy_d;
         prog_byte_q <= prog_byte_d;
         dq_out_q    <= dq_out_d;
         dq_oe_q     <= dq_oe_d;
      end
   end

   // The array erases to all ones on reset, which also discards any half-finished program.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= 8'hFF;
      end else if (mem_we) begin
         mem_q[mem_waddr] <= mem_wdata;
      end
   end

endmodule

// File: tb/tb_spi_flash_responder.sv
// Directed and randomized bench for spi_flash_responder against a byte-array flash model.
// Honours SPI_FLASH_QUAD_READ_EN to choose the expected 0x6B behaviour.
module tb_spi_flash_responder;

   logic clk;
   logic reset;
   spi_flash_responder_if bus ();

   spi_flash_responder #(.MEM_AW(8), .BUSY_CYCLES(64)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic [7:0] model_mem [256];
   logic       model_wel;
   logic       model_busy;
   logic [7:0] rd_buf [8];
   logic [3:0] nib_buf [16];
   logic [7:0] wr_buf [8];
   logic       oe_bad;

   task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed 0x%02h expected 0x%02h", tag, obs, exp);
      end
   endtask

   task automatic send_bit(input logic b);
      @(negedge clk);
      bus.flash_cs = 1'b0;
      bus.si       = b;
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      for (int i = 7; i >= 0; i--) send_bit(b[i]);
   endtask

   task automatic send_addr(input logic [23:0] a);
      for (int i = 23; i >= 0; i--) send_bit(a[i]);
   endtask

   task automatic end_cmd();
      @(negedge clk);
      bus.flash_cs = 1'b1;
      bus.si       = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic idle_cycles(input int n);
      repeat (n) begin
         @(negedge clk);
         bus.flash_cs = 1'b1;
         @(posedge clk);
      end
      #1;
   endtask

   // Each output bit is visible right after the edge that produced it.
   task automatic collect_serial(input int n);
      oe_bad = 1'b0;
      for (int k = 0; k < n; k++) begin
         for (int b = 7; b >= 0; b--) begin
            rd_buf[k][b] = bus.dq_out[1];
            if (bus.dq_oe !== 4'b0010 || bus.dq_out[3:2] !== 2'b00 || bus.dq_out[0] !== 1'b0) oe_bad = 1'b1;
            if (!(k == n - 1 && b == 0)) send_bit(1'b0);
         end
      end
   endtask

   task automatic collect_quad(input int n);
      oe_bad = 1'b0;
      for (int k = 0; k < 2 * n; k++) begin
         nib_buf[k] = bus.dq_out;
         if (bus.dq_oe !== 4'b1111) oe_bad = 1'b1;
         if (k != 2 * n - 1) send_bit(1'b0);
      end
   endtask

   task automatic do_read(input logic [23:0] a, input int n);
      send_byte(8'h03);
      send_addr(a);
      collect_serial(n);
      end_cmd();
   endtask

   task automatic do_rdsr(input int n);
      send_byte(8'h05);
      collect_serial(n);
      end_cmd();
   endtask

   task automatic do_cmd(input logic [7:0] op);
      send_byte(op);
      end_cmd();
      if (op == 8'h06 && !model_busy) model_wel = 1'b1;
      if (op == 8'h04 && !model_busy) model_wel = 1'b0;
   endtask

   // Program: only accepted with WEL set and not busy; bits only go 1 -> 0 within the page.
   task automatic do_prog(input logic [23:0] a, input int n);
      logic [7:0] idx;
      send_byte(8'h02);
      send_addr(a);
      for (int i = 0; i < n; i++) send_byte(wr_buf[i]);
      end_cmd();
      if (model_wel && !model_busy && n > 0) begin
         for (int i = 0; i < n; i++) begin
            idx = a[7:0] + 8'(i);
            model_mem[idx] = model_mem[idx] & wr_buf[i];
         end
         model_wel  = 1'b0;
         model_busy = 1'b1;
      end
   endtask

   task automatic wait_busy();
      idle_cycles(70);
      model_busy = 1'b0;
   endtask

   task automatic model_reset();
      for (int i = 0; i < 256; i++) model_mem[i] = 8'hFF;
      model_wel  = 1'b0;
      model_busy = 1'b0;
   endtask

   task automatic check_read(input string tag, input logic [23:0] a, input int n);
      logic [7:0] idx;
      do_read(a, n);
      check8({tag, "_oe"}, {7'd0, oe_bad}, 8'h00);
      for (int k = 0; k < n; k++) begin
         idx = a[7:0] + 8'(k);
         check8(tag, rd_buf[k], model_mem[idx]);
      end
   endtask

   task automatic check_status(input string tag, input int n);
      do_rdsr(n);
      check8({tag, "_oe"}, {7'd0, oe_bad}, 8'h00);
      for (int k = 0; k < n; k++) check8(tag, rd_buf[k], {6'b0, model_wel, model_busy});
   endtask

   initial begin
      logic [23:0] ra;
      int          rn;

      bus.flash_cs = 1'b1;
      bus.si       = 1'b0;
      reset        = 1'b1;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check8("reset_oe", {4'h0, bus.dq_oe}, 8'h00);
      check8("reset_dq", {4'h0, bus.dq_out}, 8'h00);
      @(negedge clk);
      reset = 1'b0;
      idle_cycles(2);

      $display("[TB] status and erased read");
      check_status("rdsr_reset", 2);
      check_read("read_erased", 24'h000010, 2);

      $display("[TB] write enable latch");
      do_cmd(8'h06);
      check_status("rdsr_wren", 1);
      do_cmd(8'h04);
      check_status("rdsr_wrdi", 1);

      $display("[TB] program and busy");
      do_cmd(8'h06);
      wr_buf[0] = 8'hA5;
      wr_buf[1] = 8'h3C;
      do_prog(24'h000020, 2);
      check_status("rdsr_busy", 2);
      do_cmd(8'h06);
      check_status("rdsr_busy_wren", 1);
      wait_busy();
      check_status("rdsr_done", 1);
      check_read("read_prog", 24'h000020, 2);
      check_read("read_upper_addr", 24'hABCD20, 2);

      $display("[TB] program without write enable");
      wr_buf[0] = 8'h00;
      do_prog(24'h000030, 1);
      wait_busy();
      check_read("read_noprog", 24'h000030, 1);
      check_status("rdsr_noprog", 1);

      $display("[TB] address wrap");
      do_cmd(8'h06);
      wr_buf[0] = 8'h11;
      wr_buf[1] = 8'h22;
      wr_buf[2] = 8'h33;
      do_prog(24'h0000FE, 3);
      wait_busy();
      check8("model_wrap_seed", model_mem[8'h00], 8'h33);
      check_read("read_wrap", 24'h0000FE, 3);

      $display("[TB] quad read opcode");
      send_byte(8'h6B);
      send_addr(24'h000020);
`ifdef SPI_FLASH_QUAD_READ_EN
      repeat (8) send_bit(1'b0);
      collect_quad(2);
      end_cmd();
      check8("quad_oe", {7'd0, oe_bad}, 8'h00);
      check8("quad_n0", {4'h0, nib_buf[0]}, {4'h0, model_mem[8'h20][7:4]});
      check8("quad_n1", {4'h0, nib_buf[1]}, {4'h0, model_mem[8'h20][3:0]});
      check8("quad_n2", {4'h0, nib_buf[2]}, {4'h0, model_mem[8'h21][7:4]});
      check8("quad_n3", {4'h0, nib_buf[3]}, {4'h0, model_mem[8'h21][3:0]});
`else
      oe_bad = 1'b0;
      for (int i = 0; i < 16; i++) begin
         if (bus.dq_oe !== 4'b0000 || bus.dq_out !== 4'b0000) oe_bad = 1'b1;
         send_bit(1'b1);
      end
      if (bus.dq_oe !== 4'b0000) oe_bad = 1'b1;
      end_cmd();
      check8("quad_disabled_oe", {7'd0, oe_bad}, 8'h00);
`endif

      $display("[TB] reset during program");
      do_cmd(8'h06);
      send_byte(8'h02);
      send_addr(24'h000040);
      send_bit(1'b0);
      send_bit(1'b1);
      send_bit(1'b0);
      send_bit(1'b0);
      @(negedge clk);
      reset = 1'b1;
      #1;
      check8("reset_mid_oe", {4'h0, bus.dq_oe}, 8'h00);
      bus.flash_cs = 1'b1;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      model_reset();
      idle_cycles(2);
      check_read("read_after_reset", 24'h000040, 1);
      check_status("rdsr_after_reset", 1);

      $display("[TB] randomized program/read");
      for (int it = 0; it < 8; it++) begin
         ra = 24'($urandom);
         rn = $urandom_range(1, 4);
         for (int i = 0; i < rn; i++) wr_buf[i] = 8'($urandom);
         if ($urandom_range(0, 3) != 0) do_cmd(8'h06);
         do_prog(ra, rn);
         if (model_busy) wait_busy();
         check_read("rand_readback", ra, rn);
         check_read("rand_other", 24'($urandom), 2);
         check_status("rand_rdsr", 1);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
